// File: rtl/mio_bus_pkg.sv
// mio_bus_pkg: shared regions, FSM states and constants for the MIO bus
package mio_bus_pkg;

    typedef enum logic [2:0] {REG_RAM, REG_SEG, REG_LED, REG_CNT, REG_BAD} region_e;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

    localparam logic [3:0] BASE_RAM = 4'h0;
    localparam logic [3:0] BASE_SEG = 4'hE;
    localparam logic [3:0] BASE_IO  = 4'hF;

    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/mio_addr_decode.sv
// mio_addr_decode: maps addr[31:28] and addr[2] to a bus region; MIO_BUS_ERR_EN makes unmapped windows REG_BAD instead of aliasing RAM
module mio_addr_decode
    import mio_bus_pkg::*;
(
    input  logic [3:0] addr_hi,
    input  logic       addr_sel,
    output region_e    region
);

`ifdef MIO_BUS_ERR_EN
    localparam region_e UNMAPPED = REG_BAD;
`else
    localparam region_e UNMAPPED = REG_RAM;
`endif

    // 0xF splits on addr[2] into LED/GPIO and counter
    always_comb begin
        region = addr_hi == BASE_RAM ? REG_RAM :
                 addr_hi == BASE_SEG ? REG_SEG :
                 addr_hi == BASE_IO  ? (addr_sel ? REG_CNT : REG_LED) :
                 UNMAPPED;
    end

endmodule

// File: rtl/mio_bus_ws.sv
// mio_bus_ws: CPU-to-RAM/GPIO bus with RAM wait states and a one-cycle ready strobe (MIO_BUS_ERR_EN enables unmapped-access errors)
module mio_bus_ws
    import mio_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] periph_wdata,
    output logic              led_we,
    output logic              seg_we,
    output logic              counter_we,
    input  logic [7:0]        sw,
    input  logic [3:0]        btn,
    input  logic [DATA_W-1:0] seg_rdata,
    input  logic [DATA_W-1:0] counter_rdata
);

    localparam logic [3:0] WAIT_INIT = 4'(RAM_LAT - 1);
    localparam bit         RAM_SLOW  = RAM_LAT > 1;

    state_e            state_q, state_d;
    region_e           region_q, region_d, dec_region;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        wait_q, wait_d;
    logic              we_q, we_d;
    logic              ram_we_q, ram_we_d;
    logic              led_we_q, led_we_d;
    logic              seg_we_q, seg_we_d;
    logic              cnt_we_q, cnt_we_d;
    logic [DATA_W-1:0] rd_mux;
    logic              ram_wait;
    logic              unused_addr;

    assign unused_addr = ^cpu_addr;

    mio_addr_decode u_decode (
        .addr_hi (cpu_addr[31:28]),
        .addr_sel(cpu_addr[2]),
        .region  (dec_region)
    );

    // read source for the latched region; RAM only reaches here when its data is due
    always_comb begin
        rd_mux   = region_q == REG_LED ? DATA_W'({btn, sw}) :
                   region_q == REG_CNT ? counter_rdata :
                   region_q == REG_SEG ? seg_rdata :
                   region_q == REG_BAD ? DATA_W'(ERR_PATTERN) :
                   ram_rdata;
        ram_wait = !we_q && region_q == REG_RAM && RAM_SLOW;
    end

    // next-state: enables are set on entry to ACCESS so they are flop outputs for exactly that cycle
    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        ram_addr_d = ram_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wait_d     = wait_q;
        we_d       = we_q;
        ram_we_d   = 1'b0;
        led_we_d   = 1'b0;
        seg_we_d   = 1'b0;
        cnt_we_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d    = ACCESS;
                    region_d   = dec_region;
                    ram_addr_d = cpu_addr[RAM_AW+1:2];
                    wdata_d    = cpu_wdata;
                    we_d       = cpu_we;
                    ram_we_d   = cpu_we && dec_region == REG_RAM;
                    led_we_d   = cpu_we && dec_region == REG_LED;
                    seg_we_d   = cpu_we && dec_region == REG_SEG;
                    cnt_we_d   = cpu_we && dec_region == REG_CNT;
                end
            end
            ACCESS: begin
                state_d = ram_wait ? WAIT : DONE;
                wait_d  = WAIT_INIT;
                rdata_d = (!we_q && !ram_wait) ? rd_mux : rdata_q;
            end
            WAIT: begin
                wait_d  = wait_q - 4'd1;
                state_d = wait_q == 4'd1 ? DONE : WAIT;
                rdata_d = wait_q == 4'd1 ? ram_rdata : rdata_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            region_q   <= REG_RAM;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_q     <= '0;
            we_q       <= 1'b0;
            ram_we_q   <= 1'b0;
            led_we_q   <= 1'b0;
            seg_we_q   <= 1'b0;
            cnt_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            ram_addr_q <= ram_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wait_q     <= wait_d;
            we_q       <= we_d;
            ram_we_q   <= ram_we_d;
            led_we_q   <= led_we_d;
            seg_we_q   <= seg_we_d;
            cnt_we_q   <= cnt_we_d;
        end
    end

    assign cpu_rdata    = rdata_q;
    assign cpu_ready    = state_q == DONE;
    assign bus_err      = state_q == DONE && region_q == REG_BAD;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = wdata_q;
    assign periph_wdata = wdata_q;
    assign ram_we       = ram_we_q;
    assign led_we       = led_we_q;
    assign seg_we       = seg_we_q;
    assign counter_we   = cnt_we_q;

endmodule
